fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage PC owner. Sits directly downstream of the IF-input staging block.
- Consumes its redirect and control outputs: branch/jump select and address from decode, JR select and address from execute, halt, SIIC, RTI and disable-PC.
- Holds the architectural PC, EPC and halt state, and presents the fetch address and a fetch-valid qualifier to instruction memory.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- SIIC_VECTOR, 16'h0002, handler entry address on SIIC.
- PC_INC, 2, sequential increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- borj_sel  in  1  decode branch/jump taken.
- borj_addr  in  16  decode branch/jump target.
- jr_sel  in  1  execute JR/JALR taken.
- jr_addr  in  16  execute register-jump target.
- halt_sel  in  1  HALT reached.
- siic  in  1  SIIC exception request.
- rti  in  1  return-from-interrupt request.
- disable_pc  in  1  hazard stall; hold PC.
- imem_stall  in  1  instruction memory busy; hold PC.
- pc_out  out  16  current fetch address.
- pc_plus2  out  16  pc_out + PC_INC, combinational.
- fetch_valid  out  1  pc_out is a live fetch this cycle.
- epc_out  out  16  saved exception return address.
- in_handler  out  1  SIIC handler active.
- halted  out  1  processor halted.
- redirect_cnt  out  16  performance counter; see Optional Feature.
- stall_cnt  out  16  performance counter; see Optional Feature.

Behaviour:
- Reset (rst==0 at edge):
  - pc_out=RESET_PC, epc_out=0, in_handler=0, halted=0, state=RUN.
  - fetch_valid is forced to 0 while rst==0.
- States: RUN, HALTED.
  - RUN -> HALTED on halt_sel, unless jr_sel is asserted the same cycle (the halt is squashed).
  - HALTED exits only on reset.
  - In HALTED: PC, EPC and in_handler frozen; fetch_valid=0; halted=1.
- Next-PC priority in RUN, highest first:
  1. jr_sel: pc <= jr_addr. The older instruction wins; siic, rti, borj_sel and halt_sel are ignored that cycle.
  2. halt_sel: pc held, go to HALTED.
  3. siic with in_handler==0: epc <= pc_plus2, pc <= SIIC_VECTOR, in_handler <= 1.
  4. rti: pc <= epc_out, in_handler <= 0. Valid even when in_handler==0 (jumps to current EPC).
  5. borj_sel: pc <= borj_addr.
  6. disable_pc or imem_stall: pc held.
  7. Otherwise: pc <= pc_plus2.
- Redirects (items 1, 3, 4, 5) take effect even while disable_pc or imem_stall is high.
- siic while in_handler==1: ignored (no nesting); falls through to lower priorities.
- siic and rti in the same cycle: siic wins if in_handler==0, else rti wins.
- Arithmetic: 16-bit modular. 16'hFFFE + 2 wraps to 16'h0000 with no flag.
- fetch_valid = (state==RUN) && !disable_pc && !imem_stall && rst. The fetch is valid the cycle pc_out is presented.
- Latency: a redirect input at cycle N appears on pc_out at N+1.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - redirect_cnt increments on each cycle a redirect (items 1, 3, 4, 5) is taken.
  - stall_cnt increments on each RUN cycle with disable_pc or imem_stall high.
  - Both are 16-bit saturating at 16'hFFFF, reset to 0, and frozen in HALTED.
- Undefined: both ports are tied to 16'h0000 and no counter flops are synthesized.

Decomposition:
- Package fetch_pkg:
  - PC_W=16.
  - Fetch state encoding RUN=1'b0, HALTED=1'b1.
  - Default RESET_PC, SIIC_VECTOR and PC_INC constants.
- Sub-module pc_next_sel: purely combinational priority mux.
  - Inputs: the select inputs, state, in_handler, pc, pc_plus2, epc and targets.
  - Outputs: next_pc, epc load enable, in_handler next value, halt_next and the redirect flag.
- Top level holds all flops and the optional counters.

Test Plan:
- Reset then 4 idle cycles -> pc_out 0000, 0002, 0004, 0006; fetch_valid=1 from the first cycle after reset release.
- pc=0010, borj_sel=1, borj_addr=0100, same cycle as disable_pc=1 -> next pc_out=0100. Then disable_pc=1 alone for 2 cycles -> pc holds 0100 and fetch_valid=0.
- pc=0020, jr_sel=1 (jr_addr=0200) with borj_sel=1, siic=1 and halt_sel=1 -> pc=0200, halted=0, epc unchanged.
- pc=0030, siic=1 -> pc=0002, epc=0032, in_handler=1. siic again -> ignored, pc=0004. rti -> pc=0032, in_handler=0.
- pc=0040, halt_sel=1 -> halted=1 next cycle, pc stays 0040, fetch_valid=0; subsequent borj_sel/jr_sel ignored. rst=0 for one edge -> pc=0000, halted=0.
- pc=FFFE, no events -> pc=0000. With FETCH_PERF_CNT_EN: 3 redirects and 2 stall cycles -> redirect_cnt=3, stall_cnt=2. Without the macro -> both read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: PC width, FSM encoding, default
// reset/vector constants and small arithmetic helpers.
package fetch_pkg;

   localparam int PC_W = 16;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   localparam logic [PC_W-1:0] DEF_RESET_PC    = 16'h0000;
   localparam logic [PC_W-1:0] DEF_SIIC_VECTOR = 16'h0002;
   localparam int              DEF_PC_INC      = 2;

   // Modular PC increment; wraps silently at the top of the address space.
   function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a, input int inc);
      return a + PC_W'(inc);
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] a);
      return (a == {PC_W{1'b1}}) ? a : a + PC_W'(1);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux for the fetch PC unit.
// Resolves JR > HALT > SIIC > RTI > BORJ > stall > sequential and
// reports whether the chosen path is a redirect.
import fetch_pkg::*;

module pc_next_sel #(
   parameter logic [PC_W-1:0] SIIC_VECTOR = DEF_SIIC_VECTOR
) (
   input  logic            jr_sel,
   input  logic [PC_W-1:0] jr_addr,
   input  logic            halt_sel,
   input  logic            siic,
   input  logic            rti,
   input  logic            borj_sel,
   input  logic [PC_W-1:0] borj_addr,
   input  logic            disable_pc,
   input  logic            imem_stall,
   input  fetch_state_e    state,
   input  logic            in_handler,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] pc_plus2,
   input  logic [PC_W-1:0] epc,
   output logic [PC_W-1:0] next_pc,
   output logic            epc_load,
   output logic            in_handler_next,
   output logic            halt_next,
   output logic            redirect
);

   // Priority chain; in HALTED everything holds and no redirect is taken.
   always_comb begin
      next_pc         = pc;
      epc_load        = 1'b0;
      in_handler_next = in_handler;
      halt_next       = 1'b0;
      redirect        = 1'b0;
      if (state == RUN) begin
         if (jr_sel) begin
            // Older instruction in execute wins; a same-cycle halt is squashed.
            next_pc  = jr_addr;
            redirect = 1'b1;
         end else if (halt_sel) begin
            halt_next = 1'b1;
         end else if (siic && !in_handler) begin
            // No nesting: a second SIIC inside the handler falls through.
            next_pc         = SIIC_VECTOR;
            epc_load        = 1'b1;
            in_handler_next = 1'b1;
            redirect        = 1'b1;
         end else if (rti) begin
            next_pc         = epc;
            in_handler_next = 1'b0;
            redirect        = 1'b1;
         end else if (borj_sel) begin
            next_pc  = borj_addr;
            redirect = 1'b1;
         end else if (!(disable_pc || imem_stall)) begin
            next_pc = pc_plus2;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the architectural PC, EPC, handler flag and halt
// state; presents the fetch address and its valid qualifier to imem.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
import fetch_pkg::*;

module fetch_pc_unit #(
   parameter logic [PC_W-1:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [PC_W-1:0] SIIC_VECTOR = DEF_SIIC_VECTOR,
   parameter int              PC_INC      = DEF_PC_INC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            borj_sel,
   input  logic [PC_W-1:0] borj_addr,
   input  logic            jr_sel,
   input  logic [PC_W-1:0] jr_addr,
   input  logic            halt_sel,
   input  logic            siic,
   input  logic            rti,
   input  logic            disable_pc,
   input  logic            imem_stall,
   output logic [PC_W-1:0] pc_out,
   output logic [PC_W-1:0] pc_plus2,
   output logic            fetch_valid,
   output logic [PC_W-1:0] epc_out,
   output logic            in_handler,
   output logic            halted,
   output logic [PC_W-1:0] redirect_cnt,
   output logic [PC_W-1:0] stall_cnt
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, epc_q, next_pc;
   logic            inh_q, inh_d, epc_load, halt_next, redirect;
   logic            hold_req;

   assign hold_req = disable_pc || imem_stall;
   assign pc_plus2 = pc_add(pc_q, PC_INC);

   pc_next_sel #(.SIIC_VECTOR(SIIC_VECTOR)) u_sel (
      .jr_sel          (jr_sel),
      .jr_addr         (jr_addr),
      .halt_sel        (halt_sel),
      .siic            (siic),
      .rti             (rti),
      .borj_sel        (borj_sel),
      .borj_addr       (borj_addr),
      .disable_pc      (disable_pc),
      .imem_stall      (imem_stall),
      .state           (state_q),
      .in_handler      (inh_q),
      .pc              (pc_q),
      .pc_plus2        (pc_plus2),
      .epc             (epc_q),
      .next_pc         (next_pc),
      .epc_load        (epc_load),
      .in_handler_next (inh_d),
      .halt_next       (halt_next),
      .redirect        (redirect)
   );

   // Run/halt FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= RUN;
      else      state_q <= state_d;
   end

   // HALTED is sticky; only reset leaves it.
   always_comb begin
      state_d = state_q;
      if (state_q == RUN && halt_next) state_d = HALTED;
   end

   // PC, EPC and handler flag; the selector already holds them in HALTED.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q  <= RESET_PC;
         epc_q <= '0;
         inh_q <= 1'b0;
      end else begin
         pc_q  <= next_pc;
         inh_q <= inh_d;
         if (epc_load) epc_q <= pc_plus2;
      end
   end

   assign pc_out      = pc_q;
   assign epc_out     = epc_q;
   assign in_handler  = inh_q;
   assign halted      = (state_q == HALTED);
   assign fetch_valid = (state_q == RUN) && !hold_req && rst;

`ifdef FETCH_PERF_CNT_EN
   logic [PC_W-1:0] redir_cnt_q, stall_cnt_q;

   // Saturating event counters, frozen once halted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (state_q == RUN) begin
         if (redirect) redir_cnt_q <= sat_inc(redir_cnt_q);
         if (hold_req) stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign redirect_cnt = redir_cnt_q;
   assign stall_cnt    = stall_cnt_q;
`else
   logic unused_perf;
   assign unused_perf  = redirect;
   assign redirect_cnt = '0;
   assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed + randomized bench for fetch_pc_unit against a behavioural model.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        borj_sel, jr_sel, halt_sel, siic, rti, disable_pc, imem_stall;
   logic [15:0] borj_addr, jr_addr;
   logic [15:0] pc_out, pc_plus2, epc_out, redirect_cnt, stall_cnt;
   logic        fetch_valid, in_handler, halted;

   int ncmp = 0;
   int nfail = 0;

   // Reference architectural state
   logic [15:0] m_pc, m_epc, m_rc, m_sc;
   logic        m_inh, m_halt;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk(clk), .rst(rst),
      .borj_sel(borj_sel), .borj_addr(borj_addr),
      .jr_sel(jr_sel), .jr_addr(jr_addr),
      .halt_sel(halt_sel), .siic(siic), .rti(rti),
      .disable_pc(disable_pc), .imem_stall(imem_stall),
      .pc_out(pc_out), .pc_plus2(pc_plus2), .fetch_valid(fetch_valid),
      .epc_out(epc_out), .in_handler(in_handler), .halted(halted),
      .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".pc"}, pc_out, m_pc);
      chk({tag, ".epc"}, epc_out, m_epc);
      chk({tag, ".inh"}, {15'd0, in_handler}, {15'd0, m_inh});
      chk({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halt});
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".rcnt"}, redirect_cnt, m_rc);
      chk({tag, ".scnt"}, stall_cnt, m_sc);
`else
      chk({tag, ".rcnt"}, redirect_cnt, 16'h0000);
      chk({tag, ".scnt"}, stall_cnt, 16'h0000);
`endif
   endtask

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic clr_in();
      borj_sel = 0; jr_sel = 0; halt_sel = 0; siic = 0; rti = 0;
      disable_pc = 0; imem_stall = 0; borj_addr = 0; jr_addr = 0;
   endtask

   // One edge with reset low; checks the forced-invalid fetch and the reset state.
   task automatic do_reset();
      clr_in();
      rst = 0;
      #2;
      chk("rst.fv", {15'd0, fetch_valid}, 16'h0000);
      @(posedge clk);
      m_pc = 16'h0000; m_epc = 0; m_inh = 0; m_halt = 0; m_rc = 0; m_sc = 0;
      #1;
      rst = 1;
      chk_state("rst");
   endtask

   // Apply one cycle of inputs, check combinational outputs, clock, update model, check state.
   task automatic step(input string tag,
                       input logic b, input logic [15:0] ba,
                       input logic j, input logic [15:0] ja,
                       input logic h, input logic s, input logic r,
                       input logic d, input logic im);
      logic stall, redir;
      borj_sel = b; borj_addr = ba; jr_sel = j; jr_addr = ja;
      halt_sel = h; siic = s; rti = r; disable_pc = d; imem_stall = im;
      #2;
      chk({tag, ".fv"}, {15'd0, fetch_valid}, {15'd0, (!m_halt && !d && !im)});
      chk({tag, ".pc2"}, pc_plus2, m_pc + 16'd2);
      @(posedge clk);
      stall = d || im;
      redir = 0;
      if (!m_halt) begin
         if (j) begin
            m_pc = ja; redir = 1;
         end else if (h) begin
            m_halt = 1;
         end else if (s && !m_inh) begin
            m_epc = m_pc + 16'd2; m_pc = 16'h0002; m_inh = 1; redir = 1;
         end else if (r) begin
            m_pc = m_epc; m_inh = 0; redir = 1;
         end else if (b) begin
            m_pc = ba; redir = 1;
         end else if (!stall) begin
            m_pc = m_pc + 16'd2;
         end
         if (redir) m_rc = sat(m_rc);
         if (stall) m_sc = sat(m_sc);
      end
      #1;
      chk_state(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic jump(input string tag, input logic [15:0] a);
      step(tag, 1, a, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_in();
      rst = 0;
      m_pc = 0; m_epc = 0; m_inh = 0; m_halt = 0; m_rc = 0; m_sc = 0;
      @(posedge clk); #1;
      do_reset();
      chk("tp.rst_pc", pc_out, 16'h0000);

      // Sequential fetch
      for (int i = 0; i < 4; i++) idle("seq");
      chk("tp.seq_pc", pc_out, 16'h0008);

      // Branch under stall still redirects, then stall holds
      jump("to10", 16'h0010);
      step("borj_stall", 1, 16'h0100, 0, 0, 0, 0, 0, 1, 0);
      chk("tp.borj", pc_out, 16'h0100);
      step("hold1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("hold2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("tp.hold", pc_out, 16'h0100);

      // JR beats everything, halt squashed
      jump("to20", 16'h0020);
      step("jr_all", 1, 16'h0300, 1, 16'h0200, 1, 1, 0, 0, 0);
      chk("tp.jr", pc_out, 16'h0200);
      chk("tp.jr_halt", {15'd0, halted}, 16'h0000);
      chk("tp.jr_epc", epc_out, 16'h0000);

      // SIIC entry, nested SIIC ignored, RTI return
      jump("to30", 16'h0030);
      step("siic", 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("tp.siic_pc", pc_out, 16'h0002);
      chk("tp.siic_epc", epc_out, 16'h0032);
      step("siic2", 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("tp.siic2_pc", pc_out, 16'h0004);
      step("siic_rti", 0, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("tp.rti_pc", pc_out, 16'h0032);
      chk("tp.rti_inh", {15'd0, in_handler}, 16'h0000);
      step("rti_out", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("tp.rti_idle", pc_out, 16'h0032);

      // Halt is sticky until reset
      jump("to40", 16'h0040);
      step("halt", 1, 16'h0500, 0, 0, 1, 0, 0, 0, 0);
      chk("tp.halt_pc", pc_out, 16'h0040);
      chk("tp.halted", {15'd0, halted}, 16'h0001);
      jump("h_borj", 16'h0600);
      step("h_jr", 0, 0, 1, 16'h0700, 0, 1, 1, 0, 0);
      chk("tp.h_pc", pc_out, 16'h0040);
      do_reset();
      chk("tp.rst2_halted", {15'd0, halted}, 16'h0000);

      // Wrap
      jump("toFFFE", 16'hFFFE);
      idle("wrap");
      chk("tp.wrap", pc_out, 16'h0000);

      // Counter scenario: 3 redirects, 2 stall cycles
      do_reset();
      jump("c1", 16'h0080);
      step("c2", 0, 0, 1, 16'h0090, 0, 0, 0, 0, 0);
      step("c3", 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step("cs1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("cs2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef FETCH_PERF_CNT_EN
      chk("tp.rcnt3", redirect_cnt, 16'd3);
      chk("tp.scnt2", stall_cnt, 16'd2);
`else
      chk("tp.rcnt0", redirect_cnt, 16'd0);
      chk("tp.scnt0", stall_cnt, 16'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            step("rnd",
                 ($urandom_range(0, 5) == 0), 16'($urandom),
                 ($urandom_range(0, 7) == 0), 16'($urandom),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
